sw_debounce: RTL and testbench
==============================

# sw_debounce

Input conditioner for slide switches and push-buttons on the board top level. Each raw, asynchronous, bouncing switch line is synchronized into the `clk` domain and debounced. The block outputs a clean level plus single-cycle rise and fall pulses. Board tops use these outputs in place of raw `SW` bits, for example as a single-step enable in place of a switch-driven clock.

## Interface
- `N`, 10 — number of independent switch channels.
- `STABLE_CYCLES`, 50000 — consecutive mismatching samples needed to accept a new level (1 ms at 50 MHz); legal range ≥ 1.
- `CNT_W`, `$clog2(STABLE_CYCLES+1)` — width of the per-channel stability counter; derived, not overridden.

- `clk`  input  1  — single system clock; every flop in the block uses its rising edge.
- `reset`  input  1  — synchronous, active-low reset; sampled on `clk` rising edge.
- `sw_raw`  input  N  — raw switch/button levels; asynchronous, may bounce.
- `sw_clean`  output  N  — debounced, synchronized level; registered.
- `sw_rise`  output  N  — one-cycle pulse when the matching `sw_clean` bit goes 0→1; registered.
- `sw_fall`  output  N  — one-cycle pulse when the matching `sw_clean` bit goes 1→0; registered.

## Operation
- Each channel is independent. There is no cross-channel interaction and no shared counter.
- Synchronizer: two flops, `s1 <= sw_raw[i]` and `s2 <= s1`. Only `s2` feeds the debounce logic.
- Per-channel FSM, encoded implicitly by `cnt` and `s2 != clean`:
  - STABLE (`s2 == clean`): `cnt <= 0`, no output change.
  - COUNTING (`s2 != clean`, `cnt < STABLE_CYCLES-1`): `cnt <= cnt + 1`.
  - ACCEPT (`s2 != clean`, `cnt == STABLE_CYCLES-1`):
    - `clean <= s2` and `cnt <= 0`.
    - Assert `rise` if `s2 == 1`, otherwise assert `fall`, for exactly one cycle.
- Bounce: any single sample with `s2 == clean` during COUNTING returns the channel to STABLE with `cnt = 0`. A partial count is never retained.
- `cnt` never exceeds `STABLE_CYCLES-1` and never wraps.
- `STABLE_CYCLES == 1`: a level is accepted on the first mismatching `s2` sample.
- `rise` and `fall` for one channel are never high in the same cycle. Different channels may pulse in the same cycle.
- Reset (`reset == 0` at an edge), including mid-count:
  - `s1`, `s2`, `clean`, `cnt`, `rise`, and `fall` all go to 0.
  - Any in-progress count is discarded.
- Post-reset: a switch already held high produces a normal `sw_rise` once it has been stable for `STABLE_CYCLES` synchronized samples.

## Timing
- Reset values: `sw_clean = 0`, `sw_rise = 0`, `sw_fall = 0`.
- Latency: number clock edges starting with 1 at the first edge that samples the new `sw_raw` value into `s1`. Then `sw_clean` and the matching pulse change on edge `STABLE_CYCLES + 2`, provided the raw level stays stable throughout.
- `sw_rise`/`sw_fall` are high for exactly one cycle: the cycle immediately after the edge at which `sw_clean` changes. They are aligned with the new `sw_clean` value.
- Minimum accepted pulse width on `sw_raw` is `STABLE_CYCLES` clock periods. Shorter pulses are suppressed entirely.
- Throughput: a channel can accept a new level at most once every `STABLE_CYCLES` cycles.

## Structure
- Package `board_io_pkg`:
  - `DEB_STABLE_1MS_50MHZ = 50000`.
  - `DEB_STABLE_SIM = 4`.
  - Board switch width `SW_W = 10`.
  - Shared with other board tops.
- Sub-module `deb_channel` contains one channel: synchronizer, counter, FSM, and pulse regs. `sw_debounce` instantiates it `N` times in a generate loop.

## Test plan
All scenarios use `STABLE_CYCLES = 4` and `N = 10`.
- **Reset:** hold `reset = 0` for 3 cycles with `sw_raw = 10'h3FF` → `sw_clean = 0` and no pulses during reset. After release, `sw_rise = 10'h3FF` for one cycle and `sw_clean = 10'h3FF`, both on edge 6 after release.
- **Clean step:** `sw_raw[0]` goes 0→1 and is held → `sw_clean[0]` rises on edge 6 and `sw_rise[0] = 1` for exactly one cycle. Returning to 0 and holding gives `sw_fall[0]` on edge 6.
- **Bounce rejection:** `sw_raw[1]` toggles 1,1,1,0,1,1,1,0 on successive cycles → `sw_clean[1]` stays 0 and no pulse occurs. Holding high afterwards gives a rise 6 edges after the final 0→1.
- **Reset mid-count:** `sw_raw[2]` goes high, then `reset = 0` on edge 4 → no pulse. After release, the full 6-edge latency restarts.
- **Parallel channels:** `sw_raw[9]` rises and `sw_raw[3]` falls (from an accepted 1) on the same cycle → `sw_rise[9]` and `sw_fall[3]` are asserted together on edge 6, and other channels stay quiet.
- **Threshold edge:** `STABLE_CYCLES = 1` build, single-cycle raw high → accepted. The `clean` change and the pulse occur on edge 3.

Source files
------------

// File: rtl/board_io_pkg.sv
// Board-level I/O constants and types shared by the board tops.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package board_io_pkg;

  // 1 ms of stable input at a 50 MHz system clock
  localparam int DEB_STABLE_1MS_50MHZ = 50000;
  // Short stability window used by simulation builds
  localparam int DEB_STABLE_SIM = 4;
  // Number of slide switches on the board
  localparam int SW_W = 10;

  // Per-channel debounce state, decoded from the counter and the level compare
  typedef enum logic [1:0] {
    DEB_STABLE   = 2'd0,
    DEB_COUNTING = 2'd1,
    DEB_ACCEPT   = 2'd2
  } deb_state_e;

endpackage

// File: rtl/deb_channel.sv
// One switch channel: 2-flop synchronizer, stability counter, clean level and edge pulses.
// Latency: new raw level appears on clean/rise/fall at edge STABLE_CYCLES+2.
// Backpressure: none; the channel free-runs every clock.
module deb_channel
  import board_io_pkg::*;
#(
  parameter int STABLE_CYCLES = DEB_STABLE_SIM
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clean_nxt;
  logic             rise_nxt;
  logic             fall_nxt;
  deb_state_e       state;

  // Bring the asynchronous switch level into the clk domain
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Classify the channel: agreeing, still counting, or on the accepting sample
  always_comb begin
    state = DEB_STABLE;
    if (s2 != clean) begin
      state = (cnt == CNT_LAST) ? DEB_ACCEPT : DEB_COUNTING;
    end
  end

  // Next counter/level/pulse values; any agreeing sample drops a partial count
  always_comb begin
    cnt_nxt   = '0;
    clean_nxt = clean;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      DEB_STABLE: begin
        cnt_nxt = '0;
      end
      DEB_COUNTING: begin
        cnt_nxt = cnt + CNT_ONE;
      end
      DEB_ACCEPT: begin
        cnt_nxt   = '0;
        clean_nxt = s2;
        rise_nxt  = s2;
        fall_nxt  = ~s2;
      end
      default: begin
        cnt_nxt = '0;
      end
    endcase
  end

  // Counter, clean level and pulses; pulses line up with the new clean value
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
      rise  <= rise_nxt;
      fall  <= fall_nxt;
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// N independent switch debouncers producing clean levels and one-cycle rise/fall pulses.
// Latency: STABLE_CYCLES+2 clk edges from raw change to clean/pulse change.
// Backpressure: none; outputs are free-running registered levels and pulses.
module sw_debounce
  import board_io_pkg::*;
#(
  parameter int N             = SW_W,
  parameter int STABLE_CYCLES = DEB_STABLE_1MS_50MHZ
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] sw_raw,
  output logic [N-1:0] sw_clean,
  output logic [N-1:0] sw_rise,
  output logic [N-1:0] sw_fall
);

  // One fully independent channel per switch line; nothing is shared
  for (genvar i = 0; i < N; i++) begin : g_ch
    deb_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .sw_raw (sw_raw[i]),
      .clean  (sw_clean[i]),
      .rise   (sw_rise[i]),
      .fall   (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed test of sw_debounce with hand-computed expected values.
// Latency: checks at #1 after each rising edge.
// Backpressure: n/a.
module tb_sw_debounce;

  logic       clk;
  logic       reset;
  logic [9:0] sw_raw;
  logic [9:0] sw_clean;
  logic [9:0] sw_rise;
  logic [9:0] sw_fall;
  logic [9:0] sw_raw1;
  logic [9:0] sw_clean1;
  logic [9:0] sw_rise1;
  logic [9:0] sw_fall1;

  int nchecks = 0;
  int nerrs   = 0;

  sw_debounce #(.N(10), .STABLE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw),
    .sw_clean (sw_clean),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall)
  );

  sw_debounce #(.N(10), .STABLE_CYCLES(1)) dut1 (
    .clk      (clk),
    .reset    (reset),
    .sw_raw   (sw_raw1),
    .sw_clean (sw_clean1),
    .sw_rise  (sw_rise1),
    .sw_fall  (sw_fall1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk3(input string tag, input logic [9:0] c, input logic [9:0] r, input logic [9:0] f);
    check({tag, ".clean"}, {22'd0, sw_clean}, {22'd0, c});
    check({tag, ".rise"},  {22'd0, sw_rise},  {22'd0, r});
    check({tag, ".fall"},  {22'd0, sw_fall},  {22'd0, f});
  endtask

  initial begin
    reset   = 1'b0;
    sw_raw  = 10'h3FF;
    sw_raw1 = 10'h000;

    // Reset held 3 cycles with all switches high
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk3("rst_hold", 10'h000, 10'h000, 10'h000);
    end
    reset = 1'b1;
    tick(5);
    chk3("rst_e5", 10'h000, 10'h000, 10'h000);
    tick(1);
    chk3("rst_e6", 10'h3FF, 10'h3FF, 10'h000);
    tick(1);
    chk3("rst_e7", 10'h3FF, 10'h000, 10'h000);

    // Return to an all-low state
    reset  = 1'b0;
    sw_raw = 10'h000;
    tick(2);
    chk3("rst2", 10'h000, 10'h000, 10'h000);
    reset = 1'b1;
    tick(8);
    chk3("quiet", 10'h000, 10'h000, 10'h000);

    // Clean step on channel 0
    sw_raw[0] = 1'b1;
    tick(5);
    chk3("step_up_e5", 10'h000, 10'h000, 10'h000);
    tick(1);
    chk3("step_up_e6", 10'h001, 10'h001, 10'h000);
    tick(1);
    chk3("step_up_e7", 10'h001, 10'h000, 10'h000);
    sw_raw[0] = 1'b0;
    tick(5);
    chk3("step_dn_e5", 10'h001, 10'h000, 10'h000);
    tick(1);
    chk3("step_dn_e6", 10'h000, 10'h000, 10'h001);
    tick(1);
    chk3("step_dn_e7", 10'h000, 10'h000, 10'h000);

    // Bounce on channel 1: runs of three highs never reach four samples
    begin
      logic [7:0] pat;
      pat = 8'b0111_0111;
      for (int i = 0; i < 8; i++) begin
        sw_raw[1] = pat[i];
        tick(1);
        chk3("bounce", 10'h000, 10'h000, 10'h000);
      end
    end
    sw_raw[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk3("bounce_hold", 10'h000, 10'h000, 10'h000);
    end
    tick(1);
    chk3("bounce_e6", 10'h002, 10'h002, 10'h000);
    tick(1);
    chk3("bounce_e7", 10'h002, 10'h000, 10'h000);

    // Reset mid-count on channel 2
    sw_raw[2] = 1'b1;
    tick(3);
    chk3("midrst_e3", 10'h002, 10'h000, 10'h000);
    reset = 1'b0;
    tick(1);
    chk3("midrst_e4", 10'h000, 10'h000, 10'h000);
    reset = 1'b1;
    tick(5);
    chk3("midrst_rel_e5", 10'h000, 10'h000, 10'h000);
    tick(1);
    chk3("midrst_rel_e6", 10'h006, 10'h006, 10'h000);
    tick(1);
    chk3("midrst_rel_e7", 10'h006, 10'h000, 10'h000);

    // Parallel channels: accept channel 3 high, then 9 rises while 3 falls
    sw_raw[3] = 1'b1;
    tick(6);
    chk3("par_pre", 10'h00E, 10'h008, 10'h000);
    tick(1);
    sw_raw[9] = 1'b1;
    sw_raw[3] = 1'b0;
    tick(5);
    chk3("par_e5", 10'h00E, 10'h000, 10'h000);
    tick(1);
    chk3("par_e6", 10'h206, 10'h200, 10'h008);
    tick(1);
    chk3("par_e7", 10'h206, 10'h000, 10'h000);

    // STABLE_CYCLES = 1: a single-cycle raw pulse is accepted
    sw_raw1[0] = 1'b1;
    tick(1);
    sw_raw1[0] = 1'b0;
    tick(1);
    check("thr_e2.clean", {22'd0, sw_clean1}, 32'h000);
    check("thr_e2.rise",  {22'd0, sw_rise1},  32'h000);
    tick(1);
    check("thr_e3.clean", {22'd0, sw_clean1}, 32'h001);
    check("thr_e3.rise",  {22'd0, sw_rise1},  32'h001);
    check("thr_e3.fall",  {22'd0, sw_fall1},  32'h000);
    tick(1);
    check("thr_e4.clean", {22'd0, sw_clean1}, 32'h000);
    check("thr_e4.rise",  {22'd0, sw_rise1},  32'h000);
    check("thr_e4.fall",  {22'd0, sw_fall1},  32'h001);
    tick(1);
    check("thr_e5.fall",  {22'd0, sw_fall1},  32'h000);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end

endmodule
